// File: rtl/mem_stage.sv
// Memory stage of the pipeline: passes non-memory results straight to writeback
// and runs one LD/ST data-memory access at a time, with a timeout abort.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [4:0]  ex_opcode,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_value_to_write,
  input  logic [3:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic [15:0] exmem_data,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [3:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        mem_err
);

  localparam logic [4:0] OP_LD    = 5'b01101;
  localparam logic [4:0] OP_ST    = 5'b01100;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [3:0]  cap_rd, cap_rd_nxt;
  logic        cap_rw, cap_rw_nxt;

  logic        mem_req_nxt, mem_we_nxt, mem_err_nxt;
  logic [15:0] mem_addr_nxt, mem_wdata_nxt, exmem_data_nxt, wb_data_nxt;
  logic        wb_valid_nxt, wb_reg_write_nxt;
  logic [3:0]  wb_rd_nxt;
  logic        stall_raw;

  logic is_ld, is_st;
  assign is_ld = (ex_opcode == OP_LD);
  assign is_st = (ex_opcode == OP_ST);

  // Stall is forced low during reset so the upstream is never frozen by a
  // stale BUSY state.
  assign stall = stall_raw & rst_n;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    state_nxt        = state;
    cnt_nxt          = cnt;
    cap_rd_nxt       = cap_rd;
    cap_rw_nxt       = cap_rw;
    mem_req_nxt      = mem_req;
    mem_we_nxt       = mem_we;
    mem_addr_nxt     = mem_addr;
    mem_wdata_nxt    = mem_wdata;
    mem_err_nxt      = mem_err;
    exmem_data_nxt   = exmem_data;
    wb_valid_nxt     = 1'b0;
    wb_data_nxt      = wb_data;
    wb_rd_nxt        = wb_rd;
    wb_reg_write_nxt = 1'b0;
    stall_raw        = 1'b0;

    unique case (state)
      IDLE: begin
        if (ex_valid) begin
          exmem_data_nxt = ex_alu_out;
          if (is_ld || is_st) begin
            stall_raw     = 1'b1;
            state_nxt     = BUSY;
            cnt_nxt       = '0;
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = is_st;
            mem_addr_nxt  = ex_alu_out;
            mem_wdata_nxt = ex_value_to_write;
            cap_rd_nxt    = ex_rd;
            cap_rw_nxt    = ex_reg_write;
          end else begin
            wb_valid_nxt     = 1'b1;
            wb_data_nxt      = ex_alu_out;
            wb_rd_nxt        = ex_rd;
            wb_reg_write_nxt = ex_reg_write;
          end
        end
      end

      BUSY: begin
        // The held instruction leaves with the ack edge; it is not re-accepted.
        stall_raw = ~mem_ack;
        if (mem_ack) begin
          state_nxt    = IDLE;
          mem_req_nxt  = 1'b0;
          wb_valid_nxt = 1'b1;
          wb_rd_nxt    = cap_rd;
          if (mem_we) begin
            wb_data_nxt      = mem_addr;
            wb_reg_write_nxt = 1'b0;
          end else begin
            wb_data_nxt      = mem_rdata;
            wb_reg_write_nxt = cap_rw;
          end
        end else if (cnt == CNT_LAST) begin
          state_nxt        = IDLE;
          mem_req_nxt      = 1'b0;
          mem_err_nxt      = 1'b1;
          wb_valid_nxt     = 1'b1;
          wb_rd_nxt        = cap_rd;
          wb_reg_write_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      cap_rd       <= '0;
      cap_rw       <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_err      <= 1'b0;
      exmem_data   <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cap_rd       <= cap_rd_nxt;
      cap_rw       <= cap_rw_nxt;
      mem_req      <= mem_req_nxt;
      mem_we       <= mem_we_nxt;
      mem_addr     <= mem_addr_nxt;
      mem_wdata    <= mem_wdata_nxt;
      mem_err      <= mem_err_nxt;
      exmem_data   <= exmem_data_nxt;
      wb_valid     <= wb_valid_nxt;
      wb_data      <= wb_data_nxt;
      wb_rd        <= wb_rd_nxt;
      wb_reg_write <= wb_reg_write_nxt;
    end
  end

endmodule
